datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The ports SHALL be as follows, with one clock and asynchronous active-low reset:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in  in  16  instruction word
- load  in  1  capture `in` into the instruction register (IR)
- s  in  1  start execution of the IR
- w  out  1  idle/ready
- bad_op  out  1  sticky flag: last instruction was illegal
- vsel  out  2  regfile write-source select: 00=C, 01=PC, 10=sximm8, 11=mdata
- writenum, readnum  out  3 each  regfile register indices
- write  out  1  regfile write enable
- loada, loadb, loadc, loads  out  1 each  pipeline/status register enables
- asel, bsel  out  1 each  operand selects: asel=1 gives A=0; bsel=1 gives B=sximm5
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm5, sximm8  out  16 each  sign-extended IR[4:0] and IR[7:0]

Function
REQ-003 IR fields SHALL be: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-004 Legal instructions SHALL be:
- opcode 110, op 10: MOV Rn,#imm8
- opcode 110, op 00: MOV Rd,Rm{sh}
- opcode 101, op 00/01/10/11: ADD, CMP, AND and MVN respectively
- all other encodings are illegal
REQ-005 IR SHALL load on a clock edge only when load=1 and the state is WAIT; load in any other state SHALL be ignored.
REQ-006 sximm5 and sximm8 SHALL be combinational sign extensions of the current IR.
REQ-007 The FSM SHALL be Moore with states WAIT, DECODE, WIMM, GET_A, GET_B, EXEC and WRITE.
REQ-008 Every output not named for a state SHALL be 0 in that state.
REQ-009 WAIT: w=1; the FSM SHALL go to DECODE when s=1, otherwise stay in WAIT; s SHALL be ignored in every other state.
REQ-010 load=1 and s=1 in the same WAIT cycle SHALL capture the new IR, and DECODE SHALL use that new value.
REQ-011 DECODE SHALL branch as follows:
- MOV imm -> WIMM
- MOV reg -> GET_B
- ALU ops -> GET_A
- illegal -> WAIT, setting bad_op=1
REQ-012 bad_op SHALL clear on the next accepted load.
REQ-013 WIMM SHALL drive write=1, vsel=10, writenum=Rn, then go to WAIT.
REQ-014 GET_A SHALL drive readnum=Rn, loada=1, then go to GET_B.
REQ-015 GET_B SHALL drive readnum=Rm, loadb=1, then go to EXEC.
REQ-016 EXEC SHALL drive shift=sh and bsel=0, with the remaining outputs set as follows:
- MOV reg: asel=1, ALUop=00, loadc=1
- ADD/AND/MVN: asel=0, ALUop=op, loadc=1
- CMP: asel=0, ALUop=01, loads=1, loadc=0, then go to WAIT
REQ-017 WRITE SHALL drive write=1, vsel=00, writenum=Rd, then go to WAIT.
REQ-018 Cycles from the s-sampling edge to w=1 again SHALL be:
- MOV imm: 2
- CMP: 4
- MOV reg: 4
- ADD/AND/MVN: 5
- illegal: 1
REQ-019 Only CMP SHALL assert loads; status SHALL be otherwise untouched.

Reset
REQ-020 reset_n=0 SHALL immediately, independent of clk, force state=WAIT, IR=0 and bad_op=0; outputs SHALL then be w=1 and all other outputs 0.
REQ-021 Reset asserted mid-instruction SHALL abort it with no further write/loadc/loads pulses.
REQ-022 The first s is accepted on the first rising edge after reset_n deasserts.

Verification
REQ-023 MOV imm: load in=0xD007, then s=1 -> one write pulse with writenum=0, vsel=10, sximm8=0x0007; w=1 two cycles later.
REQ-024 ADD R2,R1,R0 LSL#1: in=0xA148 -> pulse sequence:
- loada with readnum=1
- loadb with readnum=0
- loadc with ALUop=00, shift=01, asel=0
- write with writenum=2, vsel=00
- w=1 after 5 cycles
REQ-025 CMP R1,R0: in=0xA900 -> loada, loadb, then loads=1 with ALUop=01; no write and no loadc; w=1 after 4 cycles.
REQ-026 MOV R3,R1 LSR: in=0xC071 -> no loada, loadb with readnum=1, EXEC with asel=1 and shift=10, write with writenum=3.
REQ-027 Illegal and robustness checks:
- in=0x0000 then s -> bad_op=1, no strobes, w=1 after 1 cycle; next load clears bad_op
- load=1 during GET_A leaves IR unchanged
- reset_n=0 during EXEC forces w=1 asynchronously with no write pulse

Source files
------------

// File: rtl/datapath_ctrl.sv
// Instruction decoder and sequencing FSM for a simple register-file datapath.
// Holds the instruction register and drives per-state control strobes from registers.
module datapath_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic        bad_op,
   output logic [1:0]  vsel,
   output logic [2:0]  writenum,
   output logic [2:0]  readnum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8
);

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WIMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE
   } state_e;

   typedef struct packed {
      logic       w;
      logic [1:0] vsel;
      logic [2:0] writenum;
      logic [2:0] readnum;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] shift;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{w: 1'b1, default: '0};

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        bad_op_q, bad_op_d;
   ctrl_t       ctrl_q;

   // Control word for a state given the IR it will see; registering this on
   // (state_d, ir_d) makes the outputs a clean Moore function of the state.
   function automatic ctrl_t ctrl_for(input state_e st, input logic [15:0] ir);
      ctrl_t c;
      c = '0;
      case (st)
         S_WAIT:  c.w = 1'b1;
         S_WIMM: begin
            c.write    = 1'b1;
            c.vsel     = 2'b10;
            c.writenum = ir[10:8];
         end
         S_GET_A: begin
            c.readnum = ir[10:8];
            c.loada   = 1'b1;
         end
         S_GET_B: begin
            c.readnum = ir[2:0];
            c.loadb   = 1'b1;
         end
         S_EXEC: begin
            c.shift = ir[4:3];
            c.bsel  = 1'b0;
            if (ir[15:13] == OPC_MOV) begin
               c.asel  = 1'b1;
               c.aluop = 2'b00;
               c.loadc = 1'b1;
            end else if (ir[12:11] == 2'b01) begin
               c.aluop = 2'b01;
               c.loads = 1'b1;
            end else begin
               c.aluop = ir[12:11];
               c.loadc = 1'b1;
            end
         end
         S_WRITE: begin
            c.write    = 1'b1;
            c.vsel     = 2'b00;
            c.writenum = ir[7:5];
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      ir_d     = ir_q;
      bad_op_d = bad_op_q;
      state_d  = state_q;
      if (state_q == S_WAIT && load) begin
         ir_d     = in;
         bad_op_d = 1'b0;
      end
      case (state_q)
         S_WAIT:   if (s) state_d = S_DECODE;
         S_DECODE: begin
            if (ir_q[15:13] == OPC_MOV && ir_q[12:11] == 2'b10)
               state_d = S_WIMM;
            else if (ir_q[15:13] == OPC_MOV && ir_q[12:11] == 2'b00)
               state_d = S_GET_B;
            else if (ir_q[15:13] == OPC_ALU)
               state_d = S_GET_A;
            else begin
               state_d  = S_WAIT;
               bad_op_d = 1'b1;
            end
         end
         S_WIMM:   state_d = S_WAIT;
         S_GET_A:  state_d = S_GET_B;
         S_GET_B:  state_d = S_EXEC;
         S_EXEC:   state_d = (ir_q[15:13] == OPC_ALU && ir_q[12:11] == 2'b01) ? S_WAIT : S_WRITE;
         S_WRITE:  state_d = S_WAIT;
         default:  state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_WAIT;
         ir_q     <= '0;
         bad_op_q <= 1'b0;
         ctrl_q   <= CTRL_IDLE;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         bad_op_q <= bad_op_d;
         ctrl_q   <= ctrl_for(state_d, ir_d);
      end
   end

   assign w        = ctrl_q.w;
   assign bad_op   = bad_op_q;
   assign vsel     = ctrl_q.vsel;
   assign writenum = ctrl_q.writenum;
   assign readnum  = ctrl_q.readnum;
   assign write    = ctrl_q.write;
   assign loada    = ctrl_q.loada;
   assign loadb    = ctrl_q.loadb;
   assign loadc    = ctrl_q.loadc;
   assign loads    = ctrl_q.loads;
   assign asel     = ctrl_q.asel;
   assign bsel     = ctrl_q.bsel;
   assign shift    = ctrl_q.shift;
   assign ALUop    = ctrl_q.aluop;
   assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
   assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: per-cycle vector table, latency/strobe
// counting per instruction class, and an asynchronous reset abort sequence.
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] din;
   logic        load, s;
   logic        w, bad_op, write, loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]  vsel, shift, ALUop;
   logic [2:0]  writenum, readnum;
   logic [15:0] sximm5, sximm8;
   logic [19:0] ctrl_act;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   datapath_ctrl dut (
      .clk(clk), .reset_n(reset_n), .in(din), .load(load), .s(s),
      .w(w), .bad_op(bad_op), .vsel(vsel), .writenum(writenum), .readnum(readnum),
      .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
      .sximm5(sximm5), .sximm8(sximm8)
   );

   assign ctrl_act = {w, vsel, writenum, readnum, write, loada, loadb, loadc, loads,
                      asel, bsel, shift, ALUop};

   typedef struct {
      logic        ld;
      logic        st;
      logic [15:0] din;
      logic [19:0] ctrl;
      logic        bad;
      logic [15:0] sx5;
      logic [15:0] sx8;
      string       tag;
   } vec_t;

   vec_t vecs[$];

   localparam logic [19:0] IDLE = {1'b1, 19'b0};
   localparam logic [19:0] DEC  = 20'b0;

   function automatic logic [19:0] o(input logic ow, input logic [1:0] ovsel,
                                     input logic [2:0] own, input logic [2:0] orn,
                                     input logic owr, input logic ola, input logic olb,
                                     input logic olc, input logic ols, input logic oasel,
                                     input logic obsel, input logic [1:0] osh,
                                     input logic [1:0] oalu);
      return {ow, ovsel, own, orn, owr, ola, olb, olc, ols, oasel, obsel, osh, oalu};
   endfunction

   task automatic add(input logic ld, input logic st, input logic [15:0] d,
                      input logic [19:0] c, input logic b, input logic [15:0] x5,
                      input logic [15:0] x8, input string tag);
      vec_t v;
      v.ld = ld; v.st = st; v.din = d; v.ctrl = c; v.bad = b;
      v.sx5 = x5; v.sx8 = x8; v.tag = tag;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one instruction and count cycles until w returns plus strobe pulses seen.
   task automatic measure(input string name, input logic [15:0] instr, input int exp_cyc,
                          input int exp_wr, input int exp_lc, input int exp_ls);
      int n, nwr, nlc, nls;
      n = 0; nwr = 0; nlc = 0; nls = 0;
      load = 1'b1; s = 1'b1; din = instr;
      step();
      load = 1'b0; s = 1'b0;
      while (w !== 1'b1 && n < 20) begin
         step();
         n++;
         nwr += int'(write);
         nlc += int'(loadc);
         nls += int'(loads);
      end
      chk({name, "_cycles"}, 32'(n), 32'(exp_cyc));
      chk({name, "_writes"}, 32'(nwr), 32'(exp_wr));
      chk({name, "_loadc"},  32'(nlc), 32'(exp_lc));
      chk({name, "_loads"},  32'(nls), 32'(exp_ls));
   endtask

   initial begin
      reset_n = 1'b0; load = 1'b0; s = 1'b0; din = 16'h0000;

      // MOV R0,#7: load, then start
      add(1,0,16'hD007, IDLE, 0, 16'h0007, 16'h0007, "movimm_load");
      add(0,1,16'hD007, DEC,  0, 16'h0007, 16'h0007, "movimm_dec");
      add(0,0,16'h0000, o(0,2'b10,3'd0,3'd0,1,0,0,0,0,0,0,2'b00,2'b00), 0, 16'h0007, 16'h0007, "movimm_wimm");
      add(0,0,16'h0000, IDLE, 0, 16'h0007, 16'h0007, "movimm_done");
      // MOV R7,#-128 with load and s together
      add(1,1,16'hD780, DEC, 0, 16'h0000, 16'hFF80, "movneg_dec");
      add(0,0,16'h0000, o(0,2'b10,3'd7,3'd0,1,0,0,0,0,0,0,2'b00,2'b00), 0, 16'h0000, 16'hFF80, "movneg_wimm");
      add(0,0,16'h0000, IDLE, 0, 16'h0000, 16'hFF80, "movneg_done");
      // ADD R2,R1,R0 LSL#1; s held in DECODE and load pulsed in GET_A are both ignored
      add(1,1,16'hA148, DEC, 0, 16'h0008, 16'h0048, "add_dec");
      add(0,1,16'h0000, o(0,2'b00,3'd0,3'd1,0,1,0,0,0,0,0,2'b00,2'b00), 0, 16'h0008, 16'h0048, "add_geta");
      add(1,0,16'hFFFF, o(0,2'b00,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00), 0, 16'h0008, 16'h0048, "add_getb_ldign");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,0,0,1,0,0,0,2'b01,2'b00), 0, 16'h0008, 16'h0048, "add_exec");
      add(0,0,16'h0000, o(0,2'b00,3'd2,3'd0,1,0,0,0,0,0,0,2'b00,2'b00), 0, 16'h0008, 16'h0048, "add_write");
      add(0,0,16'h0000, IDLE, 0, 16'h0008, 16'h0048, "add_done");
      // CMP R1,R0
      add(1,1,16'hA900, DEC, 0, 16'h0000, 16'h0000, "cmp_dec");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd1,0,1,0,0,0,0,0,2'b00,2'b00), 0, 16'h0000, 16'h0000, "cmp_geta");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,0,1,0,0,0,0,2'b00,2'b00), 0, 16'h0000, 16'h0000, "cmp_getb");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,0,0,0,1,0,0,2'b00,2'b01), 0, 16'h0000, 16'h0000, "cmp_exec");
      add(0,0,16'h0000, IDLE, 0, 16'h0000, 16'h0000, "cmp_done");
      // MOV R3,R1 LSR
      add(1,1,16'hC071, DEC, 0, 16'hFFF1, 16'h0071, "movr_dec");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd1,0,0,1,0,0,0,0,2'b00,2'b00), 0, 16'hFFF1, 16'h0071, "movr_getb");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,0,0,1,0,1,0,2'b10,2'b00), 0, 16'hFFF1, 16'h0071, "movr_exec");
      add(0,0,16'h0000, o(0,2'b00,3'd3,3'd0,1,0,0,0,0,0,0,2'b00,2'b00), 0, 16'hFFF1, 16'h0071, "movr_write");
      add(0,0,16'h0000, IDLE, 0, 16'hFFF1, 16'h0071, "movr_done");
      // MVN R7,R5
      add(1,1,16'hB8E5, DEC, 0, 16'h0005, 16'hFFE5, "mvn_dec");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,1,0,0,0,0,0,2'b00,2'b00), 0, 16'h0005, 16'hFFE5, "mvn_geta");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd5,0,0,1,0,0,0,0,2'b00,2'b00), 0, 16'h0005, 16'hFFE5, "mvn_getb");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,0,0,1,0,0,0,2'b00,2'b11), 0, 16'h0005, 16'hFFE5, "mvn_exec");
      add(0,0,16'h0000, o(0,2'b00,3'd7,3'd0,1,0,0,0,0,0,0,2'b00,2'b00), 0, 16'h0005, 16'hFFE5, "mvn_write");
      add(0,0,16'h0000, IDLE, 0, 16'h0005, 16'hFFE5, "mvn_done");
      // AND R1,R2,R3 with sh=11
      add(1,1,16'hB23B, DEC, 0, 16'hFFFB, 16'h003B, "and_dec");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd2,0,1,0,0,0,0,0,2'b00,2'b00), 0, 16'hFFFB, 16'h003B, "and_geta");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd3,0,0,1,0,0,0,0,2'b00,2'b00), 0, 16'hFFFB, 16'h003B, "and_getb");
      add(0,0,16'h0000, o(0,2'b00,3'd0,3'd0,0,0,0,1,0,0,0,2'b11,2'b10), 0, 16'hFFFB, 16'h003B, "and_exec");
      add(0,0,16'h0000, o(0,2'b00,3'd1,3'd0,1,0,0,0,0,0,0,2'b00,2'b00), 0, 16'hFFFB, 16'h003B, "and_write");
      add(0,0,16'h0000, IDLE, 0, 16'hFFFB, 16'h003B, "and_done");
      // Illegal encodings and bad_op stickiness
      add(1,1,16'h0000, DEC,  0, 16'h0000, 16'h0000, "ill0_dec");
      add(0,0,16'h0000, IDLE, 1, 16'h0000, 16'h0000, "ill0_bad");
      add(0,1,16'h0000, DEC,  1, 16'h0000, 16'h0000, "ill0_rerun");
      add(0,0,16'h0000, IDLE, 1, 16'h0000, 16'h0000, "ill0_still_bad");
      add(1,1,16'hC800, DEC,  0, 16'h0000, 16'h0000, "illmov_dec");
      add(0,0,16'h0000, IDLE, 1, 16'h0000, 16'h0000, "illmov_bad");
      add(1,0,16'hD0FF, IDLE, 0, 16'hFFFF, 16'hFFFF, "load_clears_bad");
      add(0,0,16'h1234, IDLE, 0, 16'hFFFF, 16'hFFFF, "wait_no_load");

      // Reset state
      step(); step();
      chk("reset_ctrl", 32'(ctrl_act), 32'(IDLE));
      chk("reset_bad",  32'(bad_op),   32'd0);
      chk("reset_sx5",  32'(sximm5),   32'd0);
      chk("reset_sx8",  32'(sximm8),   32'd0);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         load = vecs[i].ld; s = vecs[i].st; din = vecs[i].din;
         step();
         chk({vecs[i].tag, "_ctrl"}, 32'(ctrl_act), 32'(vecs[i].ctrl));
         chk({vecs[i].tag, "_bad"},  32'(bad_op),   32'(vecs[i].bad));
         chk({vecs[i].tag, "_sx5"},  32'(sximm5),   32'(vecs[i].sx5));
         chk({vecs[i].tag, "_sx8"},  32'(sximm8),   32'(vecs[i].sx8));
      end
      load = 1'b0; s = 1'b0;

      measure("lat_movimm",  16'hD007, 2, 1, 0, 0);
      measure("lat_add",     16'hA148, 5, 1, 1, 0);
      measure("lat_cmp",     16'hA900, 4, 0, 0, 1);
      measure("lat_movreg",  16'hC071, 4, 1, 1, 0);
      measure("lat_illegal", 16'h0000, 1, 0, 0, 0);

      // Reset asserted in EXEC of an ADD aborts it without waiting for a clock
      load = 1'b1; s = 1'b1; din = 16'hA148;
      step();
      load = 1'b0; s = 1'b0;
      step(); step(); step();
      chk("rst_pre_exec_loadc", 32'(loadc), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_ctrl", 32'(ctrl_act), 32'(IDLE));
      chk("rst_async_bad",  32'(bad_op),   32'd0);
      chk("rst_async_sx8",  32'(sximm8),   32'd0);
      step();
      chk("rst_held_ctrl", 32'(ctrl_act), 32'(IDLE));
      reset_n = 1'b1; s = 1'b1;
      step();
      s = 1'b0;
      chk("rst_first_s", 32'(ctrl_act), 32'(DEC));
      step();
      chk("rst_ir_zero_ctrl", 32'(ctrl_act), 32'(IDLE));
      chk("rst_ir_zero_bad",  32'(bad_op),   32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

endmodule
